// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU data-memory responder slice.
//  - Default data / word-index widths.
//  - Responder FSM state encoding (mirrors the requester stall FSM).
//  - Bit positions of the individual error causes that feed the sticky
//    error flag.
package cpu_mem_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 10;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    // Error cause vector layout
    localparam int ERR_MISALIGN = 0;   // addr[1:0] != 0
    localparam int ERR_OOR      = 1;   // address beyond the RAM window
    localparam int ERR_CAUSES   = 2;

endpackage

// File: rtl/data_mem_responder_if.sv
// CPU memory-stage <-> data-memory bus.
//  master (CPU side) : drives en/wr/addr/write_data/err_clr, receives data/rvalid/err
//  slave  (responder): the reverse
interface data_mem_responder_if
    import cpu_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic              data_mem_en;
    logic              data_mem_wr;
    logic [31:0]       data_mem_addr;
    logic [DATA_W-1:0] data_mem_write_data;
    logic [DATA_W-1:0] data_mem_data;
    logic              data_mem_rvalid;
    logic              data_mem_err;
    logic              err_clr;

    modport master (
        output data_mem_en, data_mem_wr, data_mem_addr, data_mem_write_data, err_clr,
        input  data_mem_data, data_mem_rvalid, data_mem_err
    );

    modport slave (
        input  data_mem_en, data_mem_wr, data_mem_addr, data_mem_write_data, err_clr,
        output data_mem_data, data_mem_rvalid, data_mem_err
    );
endinterface

// File: rtl/dmem_sram.sv
// Single-port synchronous RAM, DEPTH = 2**ADDR_W words of DATA_W bits.
// Registered read; on a write the read register takes the written data
// (write-first). Contents are never reset.
// Ports: clk, en (port enable), we (write enable), addr (word index),
//        wdata (write data), rdata (registered read data).
module dmem_sram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
                rdata_reg <= wdata;
            end else begin
                rdata_reg <= mem[addr];
            end
        end
    end

    assign rdata = rdata_reg;
endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder for the CPU memory stage.
//  Reads take one extra cycle: the request is accepted in IDLE (RAM read at
//  that edge), the FSM spends one cycle in RESP while the requester stalls
//  and holds its request, and at the end of RESP the RAM output is captured
//  into data_mem_data with rvalid high for exactly the following cycle.
//  Writes commit at the edge of the request cycle, in either state.
//  Misaligned or out-of-range addresses set a sticky error flag; the access
//  still proceeds on the truncated word index.
// Ports:
//  clk  clock, rising edge
//  rst  asynchronous active-high reset
//  bus  data_mem_responder_if.slave (en/wr/addr/write_data/err_clr in,
//       data/rvalid/err out)
module data_mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter bit ERR_ON_OOR = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus
);
    state_t state_reg, state_next;

    logic [ADDR_W-1:0]     word_idx;
    logic [31:ADDR_W+2]    addr_hi;
    logic [ERR_CAUSES-1:0] err_cause;
    logic                  err_hit;
    logic                  err_reg, err_next;

    logic                  ram_en, ram_we;
    logic [DATA_W-1:0]     ram_rdata;
    logic [DATA_W-1:0]     data_reg;
    logic                  rvalid_reg;

    // Address decode and checks
    assign word_idx = bus.data_mem_addr[ADDR_W+1:2];
    assign addr_hi  = bus.data_mem_addr[31:ADDR_W+2];

    assign err_cause[ERR_MISALIGN] = (bus.data_mem_addr[1:0] != 2'b00);
    assign err_cause[ERR_OOR]      = ERR_ON_OOR && (addr_hi != '0);
    assign err_hit                 = bus.data_mem_en && (|err_cause);

    // A new error in the same cycle as err_clr wins, so nothing is lost.
    assign err_next = (bus.err_clr ? 1'b0 : err_reg) | err_hit;

    // Writes go straight to the RAM in any state. A read only touches the
    // RAM when accepted in IDLE; in RESP it is the held copy of the request
    // already in flight.
    assign ram_we = bus.data_mem_en && bus.data_mem_wr;
    assign ram_en = bus.data_mem_en && (bus.data_mem_wr || (state_reg == IDLE));

    dmem_sram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_sram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (word_idx),
        .wdata (bus.data_mem_write_data),
        .rdata (ram_rdata)
    );

    // FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = IDLE;
        case (state_reg)
            IDLE: begin
                if (bus.data_mem_en && !bus.data_mem_wr) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Response register. RAM read data registered at the accept edge is
    // captured at the end of RESP; a write during RESP updates the RAM read
    // register at the same edge, so the captured response is the old data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_reg   <= '0;
            rvalid_reg <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            rvalid_reg <= (state_reg == RESP);
            if (state_reg == RESP) begin
                data_reg <= ram_rdata;
            end
            err_reg <= err_next;
        end
    end

    assign bus.data_mem_data   = data_reg;
    assign bus.data_mem_rvalid = rvalid_reg;
    assign bus.data_mem_err    = err_reg;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder. Inputs change right after each
// falling edge; outputs are sampled on falling edges, away from the rising
// clock edge.
module tb_data_mem_responder;
    import cpu_mem_pkg::*;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    data_mem_responder_if #(.DATA_W(32)) bus ();

    data_mem_responder #(
        .ADDR_W     (10),
        .DATA_W     (32),
        .ERR_ON_OOR (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] wdata);
        bus.data_mem_en         = 1'b1;
        bus.data_mem_wr         = 1'b1;
        bus.data_mem_addr       = addr;
        bus.data_mem_write_data = wdata;
        @(negedge clk);
        $display("[TB] write addr=%h data=%h", addr, wdata);
        bus.data_mem_en = 1'b0;
        bus.data_mem_wr = 1'b0;
    endtask

    // Issue a read, hold it through RESP, check the response cycle.
    task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] expv);
        bus.data_mem_en   = 1'b1;
        bus.data_mem_wr   = 1'b0;
        bus.data_mem_addr = addr;
        @(negedge clk);
        chk({tag, "_stall_rvalid"}, {31'd0, bus.data_mem_rvalid}, 32'd0);
        @(negedge clk);
        chk({tag, "_rvalid"}, {31'd0, bus.data_mem_rvalid}, 32'd1);
        chk({tag, "_data"}, bus.data_mem_data, expv);
        $display("[TB] read addr=%h data=%h rvalid=%0b", addr, bus.data_mem_data, bus.data_mem_rvalid);
        bus.data_mem_en = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst                     = 1'b1;
        bus.data_mem_en         = 1'b0;
        bus.data_mem_wr         = 1'b0;
        bus.data_mem_addr       = 32'd0;
        bus.data_mem_write_data = 32'd0;
        bus.err_clr             = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_data",   bus.data_mem_data, 32'd0);
        chk("rst_rvalid", {31'd0, bus.data_mem_rvalid}, 32'd0);
        chk("rst_err",    {31'd0, bus.data_mem_err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Write then read
        do_write(32'h10, 32'hDEADBEEF);
        chk("wr_no_rvalid", {31'd0, bus.data_mem_rvalid}, 32'd0);
        do_read("rd10", 32'h10, 32'hDEADBEEF);
        @(negedge clk);
        chk("rvalid_one_cycle", {31'd0, bus.data_mem_rvalid}, 32'd0);
        chk("data_hold", bus.data_mem_data, 32'hDEADBEEF);
        chk("no_err", {31'd0, bus.data_mem_err}, 32'd0);

        // Read-after-write back to back
        do_write(32'h20, 32'h1);
        do_read("raw20", 32'h20, 32'h1);
        // New read accepted in the IDLE cycle right after the response
        do_read("b2b10", 32'h10, 32'hDEADBEEF);

        // Misaligned read -> word 4, err sticky, then cleared
        do_read("mis13", 32'h13, 32'hDEADBEEF);
        chk("mis_err", {31'd0, bus.data_mem_err}, 32'd1);
        @(negedge clk);
        chk("err_sticky", {31'd0, bus.data_mem_err}, 32'd1);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        chk("err_clr", {31'd0, bus.data_mem_err}, 32'd0);

        // err_clr together with a new error keeps err set
        bus.err_clr = 1'b1;
        do_write(32'h41, 32'h55);
        bus.err_clr = 1'b0;
        chk("clr_vs_new_err", {31'd0, bus.data_mem_err}, 32'd1);
        do_read("mis41_word16", 32'h40, 32'h55);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        chk("err_clr2", {31'd0, bus.data_mem_err}, 32'd0);

        // Out-of-range write truncates to word 0
        do_write(32'h0001_0000, 32'hCAFEF00D);
        chk("oor_err", {31'd0, bus.data_mem_err}, 32'd1);
        do_read("rd0", 32'h0, 32'hCAFEF00D);

        // Write during RESP: response carries old data, RAM updated
        bus.data_mem_en   = 1'b1;
        bus.data_mem_wr   = 1'b0;
        bus.data_mem_addr = 32'h10;
        @(negedge clk);
        bus.data_mem_wr         = 1'b1;
        bus.data_mem_write_data = 32'h12345678;
        @(negedge clk);
        chk("resp_wr_rvalid", {31'd0, bus.data_mem_rvalid}, 32'd1);
        chk("resp_wr_old", bus.data_mem_data, 32'hDEADBEEF);
        $display("[TB] read-with-write-in-RESP data=%h", bus.data_mem_data);
        bus.data_mem_en = 1'b0;
        bus.data_mem_wr = 1'b0;
        do_read("rd10_new", 32'h10, 32'h12345678);

        // Reset while in RESP: pending response dropped
        bus.data_mem_en   = 1'b1;
        bus.data_mem_addr = 32'h20;
        @(negedge clk);
        rst = 1'b1;
        bus.data_mem_en = 1'b0;
        #1;
        chk("rst_resp_err", {31'd0, bus.data_mem_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_resp_dropped", {31'd0, bus.data_mem_rvalid}, 32'd0);
        chk("rst_resp_data", bus.data_mem_data, 32'd0);
        @(negedge clk);
        chk("rst_resp_dropped2", {31'd0, bus.data_mem_rvalid}, 32'd0);

        // Reset during the rvalid cycle acts immediately
        bus.data_mem_en   = 1'b1;
        bus.data_mem_addr = 32'h10;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_rvalid", {31'd0, bus.data_mem_rvalid}, 32'd1);
        bus.data_mem_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("async_rvalid", {31'd0, bus.data_mem_rvalid}, 32'd0);
        chk("async_data", bus.data_mem_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Normal operation after reset
        do_read("post_rst20", 32'h20, 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
